latch_edge_qualifier: RTL and testbench

- Downstream stage for the D-latch output `q`.
- The latch is transparent while its enable is high, so `q` can change mid-cycle and can carry short pulses.
- This block does the following, in order:
  - synchronises `q` into the `clk` domain;
  - rejects pulses shorter than `STABLE` cycles;
  - emits a filtered level plus one-cycle edge strobes;
  - keeps saturating rising and falling edge counts for the lab bench and later stages.

---
 rtl/latch_edge_qualifier.sv | 157 +++++++++++++++
 tb/tb_latch_edge_qualifier.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/latch_edge_qualifier.sv
// Synchronises and debounces a D-latch output, emits a filtered level, one-cycle
// edge strobes, and saturating rising/falling edge counts with a sticky saturation flag.
`timescale 1ns/1ps
module latch_edge_qualifier #(
   parameter int WIDTH  = 8,
   parameter int STABLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             q_in,
   input  logic             clr,
   output logic             q_filt,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [WIDTH-1:0] rise_cnt,
   output logic [WIDTH-1:0] fall_cnt,
   output logic             sat
);

   typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

   localparam logic [3:0]       STAB_LAST = 4'(STABLE - 1);
   localparam logic [3:0]       STAB_ONE  = 4'd1;
   localparam logic [WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state, w_state_nxt;
   logic             r_s1, r_s2;
   logic [3:0]       r_stab, w_stab_nxt;
   logic             w_rise, w_fall;
   logic             r_rise_pulse, r_fall_pulse;
   logic [WIDTH-1:0] r_rise_cnt, r_fall_cnt;
   logic [WIDTH-1:0] w_rise_nxt, w_fall_nxt;
   logic             r_sat, w_sat_nxt;

   // Two-flop synchroniser; only r_s2 is trusted downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= q_in;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= LOW;
         r_stab  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_stab  <= w_stab_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stab_nxt  = r_stab;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      case (r_state)
         LOW: begin
            if (r_s2) begin
               // A one-cycle qualifier commits straight from the stable state.
               if (STABLE == 1) begin
                  w_state_nxt = HIGH;
                  w_stab_nxt  = 4'd0;
                  w_rise      = 1'b1;
               end else begin
                  w_state_nxt = RISE_PEND;
                  w_stab_nxt  = STAB_ONE;
               end
            end else begin
               w_stab_nxt = 4'd0;
            end
         end
         RISE_PEND: begin
            if (!r_s2) begin
               w_state_nxt = LOW;
               w_stab_nxt  = 4'd0;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = HIGH;
               w_stab_nxt  = 4'd0;
               w_rise      = 1'b1;
            end else begin
               w_stab_nxt = r_stab + STAB_ONE;
            end
         end
         HIGH: begin
            if (!r_s2) begin
               if (STABLE == 1) begin
                  w_state_nxt = LOW;
                  w_stab_nxt  = 4'd0;
                  w_fall      = 1'b1;
               end else begin
                  w_state_nxt = FALL_PEND;
                  w_stab_nxt  = STAB_ONE;
               end
            end else begin
               w_stab_nxt = 4'd0;
            end
         end
         FALL_PEND: begin
            if (r_s2) begin
               w_state_nxt = HIGH;
               w_stab_nxt  = 4'd0;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = LOW;
               w_stab_nxt  = 4'd0;
               w_fall      = 1'b1;
            end else begin
               w_stab_nxt = r_stab + STAB_ONE;
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_stab_nxt  = 4'd0;
         end
      endcase
   end

   assign w_rise_nxt = (w_rise && r_rise_cnt != CNT_MAX) ? r_rise_cnt + CNT_ONE : r_rise_cnt;
   assign w_fall_nxt = (w_fall && r_fall_cnt != CNT_MAX) ? r_fall_cnt + CNT_ONE : r_fall_cnt;
   assign w_sat_nxt  = r_sat | (&w_rise_nxt) | (&w_fall_nxt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rise_pulse <= 1'b0;
         r_fall_pulse <= 1'b0;
      end else begin
         r_rise_pulse <= w_rise;
         r_fall_pulse <= w_fall;
      end
   end

   // Clear wins over a same-cycle commit; the strobe above still fires.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_rise_cnt <= '0;
         r_fall_cnt <= '0;
         r_sat      <= 1'b0;
      end else begin
         r_rise_cnt <= w_rise_nxt;
         r_fall_cnt <= w_fall_nxt;
         r_sat      <= w_sat_nxt;
      end
   end

   assign q_filt     = (r_state == HIGH) || (r_state == FALL_PEND);
   assign rise_pulse = r_rise_pulse;
   assign fall_pulse = r_fall_pulse;
   assign rise_cnt   = r_rise_cnt;
   assign fall_cnt   = r_fall_cnt;
   assign sat        = r_sat;

endmodule

// File: tb/tb_latch_edge_qualifier.sv
// Scoreboard bench for latch_edge_qualifier: a run-length reference model pushes the
// expected outputs at every clock edge, and a monitor compares them half a cycle later.
`timescale 1ns/1ps
module tb_latch_edge_qualifier;

   localparam int W   = 3;
   localparam int S   = 3;
   localparam int MAX = (1 << W) - 1;

   logic         clk, rst_n, q_in, clr;
   logic         q_filt, rise_pulse, fall_pulse, sat;
   logic [W-1:0] rise_cnt, fall_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic         filt;
      logic         rp;
      logic         fp;
      logic [W-1:0] rc;
      logic [W-1:0] fc;
      logic         sat;
   } obs_t;

   obs_t exp_q[$];

   latch_edge_qualifier #(.WIDTH(W), .STABLE(S)) dut (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
      .q_filt(q_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .sat(sat)
   );

   initial clk = 1'b0;
   always #60 clk = ~clk;

   // Reference: the observed level is the input sampled two edges earlier; a new
   // level is accepted after S consecutive observations that differ from the filtered one.
   logic m_samp[$];
   logic m_filt, m_rp, m_fp, m_sat, m_obs;
   int   m_run, m_rc, m_fc;

   always @(posedge clk) begin
      obs_t e;
      m_rp = 1'b0;
      m_fp = 1'b0;
      if (!rst_n) begin
         m_samp = {1'b0, 1'b0};
         m_filt = 1'b0;
         m_run  = 0;
         m_rc   = 0;
         m_fc   = 0;
         m_sat  = 1'b0;
      end else begin
         m_samp.push_back(q_in);
         m_obs = m_samp.pop_front();
         if (m_obs != m_filt) m_run++;
         else m_run = 0;
         if (m_run == S) begin
            m_filt = m_obs;
            m_run  = 0;
            if (m_obs) begin
               m_rp = 1'b1;
               if (m_rc < MAX) m_rc++;
            end else begin
               m_fp = 1'b1;
               if (m_fc < MAX) m_fc++;
            end
         end
         if (m_rc == MAX || m_fc == MAX) m_sat = 1'b1;
         if (clr) begin
            m_rc  = 0;
            m_fc  = 0;
            m_sat = 1'b0;
         end
      end
      e.filt = m_filt;
      e.rp   = m_rp;
      e.fp   = m_fp;
      e.rc   = W'(m_rc);
      e.fc   = W'(m_fc);
      e.sat  = m_sat;
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t a, e;
      a = '{filt: q_filt, rp: rise_pulse, fp: fall_pulse, rc: rise_cnt, fc: fall_cnt, sat: sat};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            failures++;
            $display("FAIL outputs at %0t: got filt=%b rp=%b fp=%b rc=%0d fc=%0d sat=%b, want filt=%b rp=%b fp=%b rc=%0d fc=%0d sat=%b",
                     $time, a.filt, a.rp, a.fp, a.rc, a.fc, a.sat, e.filt, e.rp, e.fp, e.rc, e.fc, e.sat);
         end
      end
   end

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, want);
      end
   endtask

   task automatic hold(input logic v, input int n);
      q_in = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      q_in  = 1'b1;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // First edge after release is E0 for the held-high input; commit lands at E4.
      repeat (4) @(negedge clk);
      chk("reset_requal_not_early", int'(rise_pulse), 0);
      @(negedge clk);
      chk("reset_requal_pulse", int'(rise_pulse), 1);
      chk("reset_requal_cnt", int'(rise_cnt), 1);
      repeat (3) @(negedge clk);

      // Clean pulse.
      hold(1'b0, 8);
      hold(1'b1, 10);
      hold(1'b0, 8);

      // Glitch train, toggles kept clear of the rising edge.
      #10;
      for (int i = 0; i < 8; i++) begin
         q_in = ~q_in;
         #150;
      end
      @(negedge clk);
      hold(1'b0, 8);

      // Saturation over nine clean rises, then clear while high.
      for (int i = 0; i < 9; i++) begin
         hold(1'b1, 6);
         hold(1'b0, 6);
      end
      chk("sat_rise_cnt", int'(rise_cnt), MAX);
      chk("sat_flag", int'(sat), 1);
      hold(1'b1, 6);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_rise_cnt", int'(rise_cnt), 0);
      chk("clr_sat", int'(sat), 0);
      chk("clr_q_filt_kept", int'(q_filt), 1);
      hold(1'b1, 2);
      hold(1'b0, 8);

      // Clear on the exact commit edge.
      q_in = 1'b1;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("collide_pulse", int'(rise_pulse), 1);
      chk("collide_cnt", int'(rise_cnt), 0);
      hold(1'b1, 6);
      hold(1'b0, 8);
      hold(1'b1, 8);
      chk("after_collide_cnt", int'(rise_cnt), 1);

      // Reset while the rise is pending.
      hold(1'b0, 8);
      q_in = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midqual_reset_filt", int'(q_filt), 0);
      rst_n = 1'b1;
      hold(1'b1, 10);

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) q_in = 1'($urandom_range(0, 1));
         clr   = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 199) != 0);
         @(negedge clk);
      end
      clr   = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
